// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// boot_loader : HPS byte-stream initiator for the 16x8 program memory boot-load
//               port; optional readback verify is compiled in by BOOT_VERIFY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_loader #(
  parameter int LOAD_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Start,
  input  logic [3:0] LoadCount,
  input  logic [7:0] ByteData,
  input  logic       ByteValid,
  output logic       ByteReady,
  output logic       BootLoad,
  output logic [3:0] BootLoadAddress,
  output logic [7:0] WriteToMemory,
  input  logic [7:0] ReadFromMemory,
  output logic       CpuHold,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic [3:0] ErrorAddress
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RECV   = 3'd1,
    WRITE  = 3'd2,
    VSET   = 3'd3,
    VWAIT  = 3'd4,
    VCHECK = 3'd5,
    FINISH = 3'd6
  } state_t;

  localparam logic [3:0] DEPTH = 4'(LOAD_DEPTH);

  state_t     state;
  logic [3:0] addr;
  logic [3:0] count;
  logic [3:0] load_n;
  logic       last;

  assign load_n = (LoadCount > DEPTH) ? DEPTH : LoadCount;
  assign last   = (addr == count - 4'd1);

`ifdef BOOT_VERIFY_EN
  localparam int SW = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
  logic [7:0] shadow [LOAD_DEPTH];
`else
  logic unused_read;
  assign unused_read = ^ReadFromMemory;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      addr            <= '0;
      count           <= '0;
      ByteReady       <= 1'b0;
      BootLoad        <= 1'b0;
      BootLoadAddress <= '0;
      WriteToMemory   <= '0;
      CpuHold         <= 1'b0;
      Busy            <= 1'b0;
      Done            <= 1'b0;
      Error           <= 1'b0;
      ErrorAddress    <= '0;
`ifdef BOOT_VERIFY_EN
      for (int i = 0; i < LOAD_DEPTH; i++) shadow[i] <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            Done         <= 1'b0;
            Error        <= 1'b0;
            ErrorAddress <= '0;
            addr         <= '0;
            count        <= load_n;
            Busy         <= 1'b1;
            CpuHold      <= 1'b1;
            if (load_n == 4'd0) begin
              state <= FINISH;
            end else begin
              ByteReady <= 1'b1;
              state     <= RECV;
            end
          end
        end
        RECV: begin
          // ByteReady drops on the accepting edge: one byte per RECV visit.
          if (ByteValid) begin
            ByteReady       <= 1'b0;
            WriteToMemory   <= ByteData;
            BootLoadAddress <= addr;
            BootLoad        <= 1'b1;
`ifdef BOOT_VERIFY_EN
            shadow[addr[SW-1:0]] <= ByteData;
`endif
            state <= WRITE;
          end
        end
        WRITE: begin
          BootLoad <= 1'b0;
          if (last) begin
`ifdef BOOT_VERIFY_EN
            addr            <= '0;
            BootLoadAddress <= '0;
            state           <= VSET;
`else
            state <= FINISH;
`endif
          end else begin
            addr      <= addr + 4'd1;
            ByteReady <= 1'b1;
            state     <= RECV;
          end
        end
`ifdef BOOT_VERIFY_EN
        VSET:  state <= VWAIT;
        // Memory read is registered: the address needs one cycle before data appears.
        VWAIT: state <= VCHECK;
        VCHECK: begin
          if (ReadFromMemory != shadow[addr[SW-1:0]]) begin
            Error        <= 1'b1;
            ErrorAddress <= addr;
            state        <= FINISH;
          end else if (last) begin
            state <= FINISH;
          end else begin
            addr            <= addr + 4'd1;
            BootLoadAddress <= addr + 4'd1;
            state           <= VWAIT;
          end
        end
`endif
        FINISH: begin
          Done    <= 1'b1;
          Busy    <= 1'b0;
          CpuHold <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
// tb_boot_loader : directed and random load sequences against a reference model
// Revision       : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

  localparam int LOAD_DEPTH = 8;
  localparam int BUDGET     = 400;

  logic       clk;
  logic       reset;
  logic       Start;
  logic [3:0] LoadCount;
  logic [7:0] ByteData;
  logic       ByteValid;
  logic       ByteReady;
  logic       BootLoad;
  logic [3:0] BootLoadAddress;
  logic [7:0] WriteToMemory;
  logic [7:0] rdata;
  logic       CpuHold;
  logic       Busy;
  logic       Done;
  logic       Error;
  logic [3:0] ErrorAddress;

  int n_checks = 0;
  int n_fail   = 0;

  boot_loader #(.LOAD_DEPTH(LOAD_DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .Start          (Start),
    .LoadCount      (LoadCount),
    .ByteData       (ByteData),
    .ByteValid      (ByteValid),
    .ByteReady      (ByteReady),
    .BootLoad       (BootLoad),
    .BootLoadAddress(BootLoadAddress),
    .WriteToMemory  (WriteToMemory),
    .ReadFromMemory (rdata),
    .CpuHold        (CpuHold),
    .Busy           (Busy),
    .Done           (Done),
    .Error          (Error),
    .ErrorAddress   (ErrorAddress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16x8 memory with registered read; one address can be made to read back flipped.
  logic [7:0] mem [16];
  int corrupt_addr = 15;
  always @(posedge clk) begin
    if (BootLoad) mem[BootLoadAddress] <= WriteToMemory;
    else rdata <= mem[BootLoadAddress] ^ ((int'(BootLoadAddress) == corrupt_addr) ? 8'h01 : 8'h00);
  end

  logic [11:0] wlog [$];
  int ready_cnt = 0;
  always @(posedge clk) begin
    if (BootLoad) wlog.push_back({BootLoadAddress, WriteToMemory});
    if (ByteReady) ready_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_load(input int lc, input int gap, input int corr, input bit inject,
                          input bit directed);
    logic [7:0] b [16];
    int n, idx, gapcnt, cyc, wbase, rbase, checks, exp_lat, exp_ea;
    bit xfer, done_seen, exp_err;
    n = (lc > LOAD_DEPTH) ? LOAD_DEPTH : lc;
    for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
    if (directed) begin
      b[0] = 8'h1A; b[1] = 8'h2B; b[2] = 8'h3C;
    end
    corrupt_addr = corr;
    wbase = wlog.size();
    rbase = ready_cnt;
    LoadCount = 4'(lc);
    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    ByteValid = (n > 0);
    ByteData = b[0];
    idx = 0; gapcnt = 0; cyc = 0; done_seen = 1'b0;
    while (!done_seen && cyc < BUDGET) begin
      xfer = ByteValid && ByteReady;
      @(posedge clk);
      cyc++;
      if (xfer) begin
        idx++;
        gapcnt = gap;
      end
      #1;
      if (idx < n && gapcnt == 0) begin
        ByteValid = 1'b1;
        ByteData  = b[idx];
      end else begin
        ByteValid = 1'b0;
        ByteData  = 8'($urandom);
        if (gapcnt > 0) gapcnt--;
      end
      Start = inject && (cyc == 3) && !Done;
      LoadCount = 4'($urandom);
      done_seen = Done;
    end
    Start = 1'b0;
    ByteValid = 1'b0;

`ifdef BOOT_VERIFY_EN
    exp_err = (corr < n);
    checks  = exp_err ? corr + 1 : n;
    exp_lat = (n == 0) ? 1 : 2 * n + 1 + 2 * checks + 1;
`else
    exp_err = 1'b0;
    exp_lat = 2 * n + 1;
`endif
    exp_ea = exp_err ? corr : 0;

    check("done_reached", 32'(done_seen), 32'd1);
    check("busy_after", 32'(Busy), 32'd0);
    check("cpuhold_after", 32'(CpuHold), 32'd0);
    check("bootload_after", 32'(BootLoad), 32'd0);
    check("error", 32'(Error), 32'(exp_err));
    check("error_addr", 32'(ErrorAddress), 32'(exp_ea));
    check("write_count", 32'(wlog.size() - wbase), 32'(n));
    for (int i = 0; i < n && wbase + i < wlog.size(); i++)
      check("write_addr_data", 32'(wlog[wbase + i]), 32'({4'(i), b[i]}));
    if (gap == 0) begin
      check("latency", 32'(cyc), 32'(exp_lat));
      check("ready_cycles", 32'(ready_cnt - rbase), 32'(n));
    end
    @(posedge clk); #1;
    check("done_sticky", 32'(Done), 32'd1);
  endtask

  int wcnt;
  int cyc2;

  initial begin
    reset = 1'b1; Start = 1'b0; LoadCount = '0; ByteData = '0; ByteValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready", 32'(ByteReady), 32'd0);
    check("rst_bootload", 32'(BootLoad), 32'd0);
    check("rst_addr", 32'(BootLoadAddress), 32'd0);
    check("rst_wdata", 32'(WriteToMemory), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_cpuhold", 32'(CpuHold), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    check("rst_error_addr", 32'(ErrorAddress), 32'd0);

    run_load(3, 0, 15, 1'b0, 1'b1);   // 1A,2B,3C clean
    run_load(0, 0, 15, 1'b0, 1'b0);   // empty load
    run_load(12, 0, 15, 1'b0, 1'b0);  // clamped to 8
    run_load(5, 0, 2, 1'b0, 1'b1);    // readback corrupt at address 2
    run_load(4, 2, 15, 1'b1, 1'b0);   // gapped stream plus Start while busy

    // Reset during the third write abandons the load.
    LoadCount = 4'd5; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; ByteValid = 1'b1; ByteData = 8'h55;
    wcnt = 0; cyc2 = 0;
    while (wcnt < 3 && cyc2 < 100) begin
      @(posedge clk); #1;
      cyc2++;
      if (BootLoad) wcnt++;
    end
    check("rst_mid_reached", 32'(wcnt), 32'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; ByteValid = 1'b0;
    check("rst_mid_bootload", 32'(BootLoad), 32'd0);
    check("rst_mid_busy", 32'(Busy), 32'd0);
    check("rst_mid_cpuhold", 32'(CpuHold), 32'd0);
    check("rst_mid_ready", 32'(ByteReady), 32'd0);
    check("rst_mid_done", 32'(Done), 32'd0);
    run_load(4, 0, 15, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++)
      run_load(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : 15, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
